// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_pkg
// Brief    : Shared types and default constants for the stopwatch blocks.
// Revision : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    localparam int c_DEFAULT_BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000;
    localparam int c_DEFAULT_TIMEOUT_CYCLES              = 200_000_000;
    localparam int c_DEFAULT_FILTER_CYCLES               = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MEASURING = 2'd1,
        STALLED   = 2'd2
    } meter_state_t;

endpackage
`default_nettype wire

// File: rtl/toggle_period_meter_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : input_conditioner
// Brief    : 2-FF synchronizer, optional stability filter and rise detector.
//            Filter built only when TOGGLE_PERIOD_METER_GLITCH_FILTER_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
module input_conditioner
    import stopwatch_pkg::*;
#(
    parameter int FILTER_CYCLES = c_DEFAULT_FILTER_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic r_sync_meta;
    logic r_sync_out;
    logic r_prev;
    logic w_level;

    if (FILTER_CYCLES < 1) begin : g_filter_cycles_check
        $error("input_conditioner: FILTER_CYCLES must be >= 1");
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync_meta <= 1'b0;
            r_sync_out  <= 1'b0;
        end else begin
            r_sync_meta <= async_in;
            r_sync_out  <= r_sync_meta;
        end
    end

`ifdef TOGGLE_PERIOD_METER_GLITCH_FILTER_EN
    localparam int c_FILT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [c_FILT_W-1:0] c_FILT_LAST = c_FILT_W'(FILTER_CYCLES - 1);

    logic [c_FILT_W-1:0] r_filt_cnt;
    logic                r_filt_level;

    // Counts consecutive samples that disagree with the filtered level;
    // any agreeing sample restarts the run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_filt_cnt   <= '0;
            r_filt_level <= 1'b0;
        end else if (r_sync_out == r_filt_level) begin
            r_filt_cnt <= '0;
        end else if (r_filt_cnt == c_FILT_LAST) begin
            r_filt_cnt   <= '0;
            r_filt_level <= r_sync_out;
        end else begin
            r_filt_cnt <= r_filt_cnt + c_FILT_W'(1);
        end
    end

    assign w_level = r_filt_level;
`else
    assign w_level = r_sync_out;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= w_level;
        end
    end

    assign rise = w_level & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/toggle_period_meter.sv
`default_nettype none
// ============================================================================
// Module   : toggle_period_meter
// Brief    : Measures rising-edge period of an async square wave, flags stalls.
//            Optional glitch filter: TOGGLE_PERIOD_METER_GLITCH_FILTER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module toggle_period_meter
    import stopwatch_pkg::*;
#(
    parameter int BOARD_CLOCK_FREQUENCY_IN_HZ = c_DEFAULT_BOARD_CLOCK_FREQUENCY_IN_HZ,
    parameter int TIMEOUT_CYCLES              = c_DEFAULT_TIMEOUT_CYCLES,
    parameter int FILTER_CYCLES               = c_DEFAULT_FILTER_CYCLES,
    parameter int COUNT_WIDTH                 = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   blink_in,
    output logic [COUNT_WIDTH-1:0] period,
    output logic                   period_valid,
    output logic                   timeout,
    output logic                   locked
);

    localparam logic [COUNT_WIDTH-1:0] c_CNT_LIMIT = COUNT_WIDTH'(TIMEOUT_CYCLES - 1);

    if (TIMEOUT_CYCLES < 4) begin : g_timeout_cycles_check
        $error("toggle_period_meter: TIMEOUT_CYCLES must be >= 4");
    end
    if (BOARD_CLOCK_FREQUENCY_IN_HZ <= 0) begin : g_clock_frequency_check
        $error("toggle_period_meter: BOARD_CLOCK_FREQUENCY_IN_HZ must be > 0");
    end

    logic                   w_rise;
    logic                   w_at_limit;
    meter_state_t           r_state;
    meter_state_t           w_state_next;
    logic [COUNT_WIDTH-1:0] r_cnt;
    logic [COUNT_WIDTH-1:0] w_cnt_next;
    logic [COUNT_WIDTH-1:0] r_period;
    logic [COUNT_WIDTH-1:0] w_period_next;
    logic                   r_period_valid;
    logic                   w_period_valid_next;
    logic                   r_timeout;
    logic                   w_timeout_next;
    logic                   r_locked;
    logic                   w_locked_next;

    input_conditioner #(
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_input_conditioner (
        .clk      (clk),
        .rst      (rst),
        .async_in (blink_in),
        .rise     (w_rise)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_period       <= '0;
            r_period_valid <= 1'b0;
            r_timeout      <= 1'b0;
            r_locked       <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_cnt          <= w_cnt_next;
            r_period       <= w_period_next;
            r_period_valid <= w_period_valid_next;
            r_timeout      <= w_timeout_next;
            r_locked       <= w_locked_next;
        end
    end

    assign w_at_limit = (r_cnt == c_CNT_LIMIT);

    // A rise always takes priority over the stall check, so an interval of
    // exactly TIMEOUT_CYCLES is still reported as a period.
    always_comb begin
        w_state_next        = r_state;
        w_cnt_next          = r_cnt + COUNT_WIDTH'(1);
        w_period_next       = r_period;
        w_period_valid_next = 1'b0;
        w_timeout_next      = r_timeout;
        w_locked_next       = r_locked;
        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_state_next = MEASURING;
                    w_cnt_next   = '0;
                end else if (w_at_limit) begin
                    w_state_next   = STALLED;
                    w_cnt_next     = r_cnt;
                    w_timeout_next = 1'b1;
                end
            end
            MEASURING: begin
                if (w_rise) begin
                    w_cnt_next          = '0;
                    w_period_next       = r_cnt + COUNT_WIDTH'(1);
                    w_period_valid_next = 1'b1;
                    w_locked_next       = 1'b1;
                end else if (w_at_limit) begin
                    w_state_next   = STALLED;
                    w_cnt_next     = r_cnt;
                    w_timeout_next = 1'b1;
                    w_locked_next  = 1'b0;
                end
            end
            STALLED: begin
                w_cnt_next = r_cnt;
                if (w_rise) begin
                    w_state_next   = MEASURING;
                    w_cnt_next     = '0;
                    w_timeout_next = 1'b0;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign period       = r_period;
    assign period_valid = r_period_valid;
    assign timeout      = r_timeout;
    assign locked       = r_locked;

endmodule
`default_nettype wire
